sram_controller: RTL and testbench

- Sequences the board's asynchronous 256K x 16 external SRAM on behalf of the data-cache controller.
- Converts one 32-bit write request into two 16-bit SRAM write beats.
- Converts one read request into four 16-bit read beats, assembled into the 64-bit line the cache fills from.
- Sits between the cache controller (sram_* request side) and the SRAM pins; owns all wait-state timing.

---
 rtl/sram_controller_pkg.sv | 16 +
 rtl/sram_controller.sv | 146 ++++++++++++++
 tb/tb_sram_controller.sv | 223 ++++++++++++++++++++++
 3 files changed

// File: rtl/sram_controller_pkg.sv
// Shared types and constants for the external 256K x 16 SRAM sequencer.
package sram_controller_pkg;

  typedef enum logic [1:0] {
    StIdle  = 2'd0,
    StRead  = 2'd1,
    StWrite = 2'd2,
    StDone  = 2'd3
  } state_e;

  localparam int unsigned MemBase   = 1024;
  localparam int unsigned SramAddrW = 18;
  localparam int unsigned SramDataW = 16;
  localparam int unsigned LineW     = 64;

endpackage

// File: rtl/sram_controller.sv
// Sequences 2-beat word writes and 4-beat line reads on the asynchronous SRAM
// for the data cache, with SRAM_WAIT+1 cycles per 16-bit beat.
module sram_controller
  import sram_controller_pkg::*;
#(
  parameter int unsigned SRAM_WAIT = 1,
  parameter int unsigned MEM_BASE  = MemBase
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rd_en,
  input  logic                 wr_en,
  input  logic [31:0]          address,
  input  logic [31:0]          write_data,
  output logic [LineW-1:0]     read_data,
  output logic                 ready,
  inout  wire  [SramDataW-1:0] SRAM_DQ,
  output logic [SramAddrW-1:0] SRAM_ADDR,
  output logic                 SRAM_WE_N,
  output logic                 SRAM_OE_N,
  output logic                 SRAM_CE_N,
  output logic                 SRAM_UB_N,
  output logic                 SRAM_LB_N
);

  localparam logic [2:0] WaitLast = 3'(SRAM_WAIT);

  state_e                 state_q, state_d;
  logic [1:0]             beat_q, beat_d;
  logic [2:0]             wcnt_q, wcnt_d;
  logic [SramAddrW-1:0]   base_q, base_d;
  logic [31:0]            wdata_q, wdata_d;
  logic [LineW-1:0]       read_data_q, read_data_d;
  logic                   ready_q, ready_d;
  logic [SramAddrW-1:0]   addr_q, addr_d;
  logic                   we_n_q, we_n_d;
  logic                   oe_n_q, oe_n_d;
  logic                   dq_oe_q, dq_oe_d;
  logic [SramDataW-1:0]   dq_out_q, dq_out_d;
  logic [16:0]            word_idx;
  logic                   beat_last;
  logic                   busy_d;

  // 32-bit word index of the request relative to the SRAM window.
  assign word_idx  = 17'((address - 32'(MEM_BASE)) >> 2);
  assign beat_last = (wcnt_q == WaitLast);

  always_comb begin
    state_d     = state_q;
    beat_d      = beat_q;
    wcnt_d      = wcnt_q;
    base_d      = base_q;
    wdata_d     = wdata_q;
    read_data_d = read_data_q;
    unique case (state_q)
      StIdle: begin
        beat_d = 2'd0;
        wcnt_d = 3'd0;
        if (wr_en) begin
          state_d = StWrite;
          base_d  = {word_idx, 1'b0};
          wdata_d = write_data;
        end else if (rd_en) begin
          state_d = StRead;
          base_d  = {word_idx[16:1], 2'b00};
        end
      end
      StRead: begin
        if (beat_last) begin
          read_data_d[{beat_q, 4'b0000} +: SramDataW] = SRAM_DQ;
          wcnt_d = 3'd0;
          beat_d = beat_q + 2'd1;
          if (beat_q == 2'd3) state_d = StDone;
        end else begin
          wcnt_d = wcnt_q + 3'd1;
        end
      end
      StWrite: begin
        if (beat_last) begin
          wcnt_d = 3'd0;
          if (beat_q == 2'd1) begin
            beat_d  = 2'd0;
            state_d = StDone;
          end else begin
            beat_d = beat_q + 2'd1;
          end
        end else begin
          wcnt_d = wcnt_q + 3'd1;
        end
      end
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase

    // Pin values are computed from the next state so they are registered yet
    // line up with the first cycle of each beat.
    busy_d   = (state_d == StRead) || (state_d == StWrite);
    addr_d   = busy_d ? SramAddrW'(base_d + {16'b0, beat_d}) : addr_q;
    we_n_d   = !((state_d == StWrite) && (wcnt_d != WaitLast));
    oe_n_d   = (state_d == StWrite);
    dq_oe_d  = (state_d == StWrite);
    dq_out_d = beat_d[0] ? wdata_d[31:16] : wdata_d[15:0];
    ready_d  = (state_d == StDone);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= StIdle;
      beat_q      <= 2'd0;
      wcnt_q      <= 3'd0;
      base_q      <= '0;
      wdata_q     <= '0;
      read_data_q <= '0;
      ready_q     <= 1'b0;
      addr_q      <= '0;
      we_n_q      <= 1'b1;
      oe_n_q      <= 1'b0;
      dq_oe_q     <= 1'b0;
      dq_out_q    <= '0;
    end else begin
      state_q     <= state_d;
      beat_q      <= beat_d;
      wcnt_q      <= wcnt_d;
      base_q      <= base_d;
      wdata_q     <= wdata_d;
      read_data_q <= read_data_d;
      ready_q     <= ready_d;
      addr_q      <= addr_d;
      we_n_q      <= we_n_d;
      oe_n_q      <= oe_n_d;
      dq_oe_q     <= dq_oe_d;
      dq_out_q    <= dq_out_d;
    end
  end

  assign SRAM_DQ   = dq_oe_q ? dq_out_q : {SramDataW{1'bz}};
  assign SRAM_ADDR = addr_q;
  assign SRAM_WE_N = we_n_q;
  assign SRAM_OE_N = oe_n_q;
  assign SRAM_CE_N = 1'b0;
  assign SRAM_UB_N = 1'b0;
  assign SRAM_LB_N = 1'b0;
  assign read_data = read_data_q;
  assign ready     = ready_q;

endmodule

// File: tb/tb_sram_controller.sv
// Self-checking bench for sram_controller against a behavioural async SRAM model.
module tb_sram_controller;

  localparam int W = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        rd_en, wr_en;
  logic [31:0] address, write_data;
  logic [63:0] read_data;
  logic        ready;
  wire  [15:0] sram_dq;
  logic [17:0] sram_addr;
  logic        we_n, oe_n, ce_n, ub_n, lb_n;

  logic [15:0] mem [256];
  logic        model_en;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic        is_rd;
    logic [17:0] base;
    logic [63:0] line;
    int          lat;
  } exp_t;
  exp_t exp_q[$];

  typedef struct {
    logic        rd;
    logic        wr;
    logic [31:0] addr;
    logic [31:0] wd;
    logic [63:0] line;
  } vec_t;
  vec_t vecs[9];

  sram_controller #(.SRAM_WAIT(W), .MEM_BASE(1024)) dut (
    .clk        (clk),
    .rst        (rst),
    .rd_en      (rd_en),
    .wr_en      (wr_en),
    .address    (address),
    .write_data (write_data),
    .read_data  (read_data),
    .ready      (ready),
    .SRAM_DQ    (sram_dq),
    .SRAM_ADDR  (sram_addr),
    .SRAM_WE_N  (we_n),
    .SRAM_OE_N  (oe_n),
    .SRAM_CE_N  (ce_n),
    .SRAM_UB_N  (ub_n),
    .SRAM_LB_N  (lb_n)
  );

  always #5 clk = ~clk;

  // Asynchronous SRAM: write latched on the rising edge of WE_N, read is combinational.
  always @(posedge we_n) begin
    if (oe_n === 1'b1) mem[sram_addr[7:0]] <= sram_dq;
  end
  assign sram_dq = (model_en && oe_n === 1'b0 && we_n === 1'b1) ? mem[sram_addr[7:0]]
                                                                  : 16'hzzzz;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic logic [17:0] rd_base(input logic [31:0] a);
    return 18'(((a - 32'd1024) >> 3) << 2);
  endfunction

  function automatic logic [17:0] wr_base(input logic [31:0] a);
    return 18'(((a - 32'd1024) >> 2) << 1);
  endfunction

  // Caller has the request on the inputs; the next edge accepts it.
  task automatic wait_done(input logic is_rd, input logic [17:0] base,
                           output int lat, output int we_lows);
    int beats;
    beats = is_rd ? 4 : 2;
    we_lows = 0;
    @(posedge clk); #1;
    lat = 1;
    while (ready !== 1'b1 && lat < 40) begin
      if (lat <= beats * (W + 1)) begin
        check(is_rd ? "rd_addr_step" : "wr_addr_step", 64'(sram_addr),
              64'(base + 18'((lat - 1) / (W + 1))));
      end
      if (we_n === 1'b0) we_lows++;
      if (lat == 2) begin
        address    = 32'h0000_07F0;
        write_data = 32'hCAFE_F00D;
      end
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_done(input int lat, input int we_lows);
    exp_t e;
    if (exp_q.size() == 0) begin
      check("sb_empty", 64'(exp_q.size()), 64'd1);
      return;
    end
    e = exp_q.pop_front();
    check("latency", 64'(lat), 64'(e.lat));
    check("read_data", read_data, e.line);
    check("we_pulses", 64'(we_lows), e.is_rd ? 64'd0 : 64'd2);
  endtask

  task automatic run_req(input logic rd, input logic wr, input logic [31:0] addr,
                         input logic [31:0] wd, input logic [63:0] line);
    exp_t e;
    int   lat, wl;
    @(negedge clk);
    rd_en = rd; wr_en = wr; address = addr; write_data = wd;
    e.is_rd = rd && !wr;
    e.base  = e.is_rd ? rd_base(addr) : wr_base(addr);
    e.line  = line;
    e.lat   = e.is_rd ? 4 * (W + 1) + 1 : 2 * (W + 1) + 1;
    exp_q.push_back(e);
    wait_done(e.is_rd, e.base, lat, wl);
    rd_en = 1'b0; wr_en = 1'b0;
    check_done(lat, wl);
    @(posedge clk); #1;
    check("ready_one_cycle", 64'(ready), 64'd0);
  endtask

  initial begin
    int   lat, wl;
    exp_t e;

    vecs[0] = '{1'b0, 1'b1, 32'h400, 32'hDEADBEEF, 64'h0};
    vecs[1] = '{1'b0, 1'b1, 32'h400, 32'h11112222, 64'h0};
    vecs[2] = '{1'b0, 1'b1, 32'h404, 32'h33334444, 64'h0};
    vecs[3] = '{1'b1, 1'b0, 32'h404, 32'h0,        64'h3333_4444_1111_2222};
    vecs[4] = '{1'b0, 1'b1, 32'h408, 32'h55556666, 64'h3333_4444_1111_2222};
    vecs[5] = '{1'b0, 1'b1, 32'h40C, 32'h77778888, 64'h3333_4444_1111_2222};
    vecs[6] = '{1'b1, 1'b0, 32'h40C, 32'h0,        64'h7777_8888_5555_6666};
    vecs[7] = '{1'b1, 1'b1, 32'h408, 32'h9999AAAA, 64'h7777_8888_5555_6666};
    vecs[8] = '{1'b1, 1'b0, 32'h408, 32'h0,        64'h7777_8888_9999_AAAA};

    for (int i = 0; i < 256; i++) mem[i] = 16'h0;
    model_en = 1'b0;
    rd_en = 1'b0; wr_en = 1'b0; address = '0; write_data = '0;
    rst = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    check("rst_ready", 64'(ready), 64'd0);
    check("rst_read_data", read_data, 64'd0);
    check("rst_we_n", 64'(we_n), 64'd1);
    check("rst_oe_n", 64'(oe_n), 64'd0);
    check("rst_addr", 64'(sram_addr), 64'd0);
    check("rst_dq_z", 64'(sram_dq === 16'hzzzz), 64'd1);
    @(negedge clk);
    rst = 1'b0;
    model_en = 1'b1;

    for (int i = 0; i < 9; i++) begin
      run_req(vecs[i].rd, vecs[i].wr, vecs[i].addr, vecs[i].wd, vecs[i].line);
      if (i == 0) begin
        check("mem0_beef", 64'(mem[0]), 64'hBEEF);
        check("mem1_dead", 64'(mem[1]), 64'hDEAD);
        model_en = 1'b0;
        #1;
        check("dq_z_after_wr", 64'(sram_dq === 16'hzzzz), 64'd1);
        model_en = 1'b1;
      end
      if (i == 7) begin
        check("both_en_mem4", 64'(mem[4]), 64'hAAAA);
        check("both_en_mem5", 64'(mem[5]), 64'h9999);
      end
    end

    // Reset in the middle of read beat 2 aborts the transaction.
    @(negedge clk);
    rd_en = 1'b1; address = 32'h404;
    @(posedge clk); #1;
    repeat (4) begin
      @(posedge clk); #1;
    end
    rd_en = 1'b0;
    rst = 1'b1;
    #1;
    check("mid_rst_ready", 64'(ready), 64'd0);
    check("mid_rst_read_data", read_data, 64'd0);
    check("mid_rst_we_n", 64'(we_n), 64'd1);
    check("mid_rst_addr", 64'(sram_addr), 64'd0);
    @(posedge clk); #1;
    check("mid_rst_idle", 64'(ready), 64'd0);
    @(negedge clk);
    rst = 1'b0;
    run_req(1'b1, 1'b0, 32'h404, 32'h0, 64'h3333_4444_1111_2222);

    // rd_en held through ready: one IDLE cycle, then a second read.
    @(negedge clk);
    rd_en = 1'b1; address = 32'h40C;
    for (int k = 0; k < 2; k++) begin
      e.is_rd = 1'b1;
      e.base  = rd_base(32'h40C);
      e.line  = 64'h7777_8888_9999_AAAA;
      e.lat   = 4 * (W + 1) + 1;
      exp_q.push_back(e);
      address = 32'h40C;
      wait_done(1'b1, e.base, lat, wl);
      if (k == 1) rd_en = 1'b0;
      check_done(lat, wl);
      @(posedge clk); #1;
      check("b2b_idle_gap", 64'(ready), 64'd0);
    end
    check("sb_drained", 64'(exp_q.size()), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
